// File: rtl/rails_dispatch.sv
// Railway station dispatcher: loads a target departure order, then
// drives PUSH/POP operations through a 10-deep stack station.
module rails_dispatch (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       op_valid,
    output logic       op_pop,
    output logic [3:0] op_car,
    input  logic       op_ready,
    output logic       done,
    output logic       result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_N = 4'd10;

    state_t     state;
    logic [3:0] n;
    logic [3:0] k;
    logic [3:0] sp;
    logic [4:0] nxt;
    logic [3:0] li;
    logic       bad;
    logic       res;
    logic [3:0] target [10];
    logic [3:0] stack  [10];

    logic [3:0] top;
    logic [3:0] tgt;
    logic       can_pop;
    logic       can_push;
    logic       word_bad;
    logic       hdr_bad;

    // Operation offer decoded from registered state only
    always_comb begin
        top      = 4'd0;
        tgt      = target[k];
        can_pop  = 1'b0;
        can_push = 1'b0;
        if (sp != 4'd0) begin
            top = stack[sp - 4'd1];
        end
        if (state == RUN) begin
            if ((sp != 4'd0) && (top == tgt)) begin
                can_pop = 1'b1;
            end else if (nxt <= {1'b0, n}) begin
                can_push = 1'b1;
            end
        end
    end

    // Input word range checks
    always_comb begin
        hdr_bad  = (data == 4'd0) || (data > MAX_N);
        word_bad = (data == 4'd0) || (data > n);
    end

    // Output decode
    always_comb begin
        in_ready = (state == IDLE) || (state == LOAD);
        op_valid = can_pop || can_push;
        op_pop   = can_pop;
        op_car   = 4'd0;
        if (can_pop) begin
            op_car = top;
        end else if (can_push) begin
            op_car = nxt[3:0];
        end
        done   = (state == DONE);
        result = res;
    end

    // Control FSM with load, dispatch and completion handling
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n     <= 4'd0;
            k     <= 4'd0;
            sp    <= 4'd0;
            nxt   <= 5'd0;
            li    <= 4'd0;
            bad   <= 1'b0;
            res   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                target[i] <= 4'd0;
                stack[i]  <= 4'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (hdr_bad) begin
                            state <= DONE;
                            res   <= 1'b0;
                        end else begin
                            n     <= data;
                            li    <= 4'd0;
                            bad   <= 1'b0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        target[li] <= data;
                        if (word_bad) begin
                            bad <= 1'b1;
                        end
                        if (li == n - 4'd1) begin
                            if (bad || word_bad) begin
                                state <= DONE;
                                res   <= 1'b0;
                            end else begin
                                state <= RUN;
                                nxt   <= 5'd1;
                                k     <= 4'd0;
                                sp    <= 4'd0;
                            end
                        end else begin
                            li <= li + 4'd1;
                        end
                    end
                end
                RUN: begin
                    if (can_pop) begin
                        if (op_ready) begin
                            sp <= sp - 4'd1;
                            k  <= k + 4'd1;
                            if (k == n - 4'd1) begin
                                state <= DONE;
                                res   <= 1'b1;
                            end
                        end
                    end else if (can_push) begin
                        if (op_ready) begin
                            stack[sp] <= nxt[3:0];
                            sp        <= sp + 4'd1;
                            nxt       <= nxt + 5'd1;
                        end
                    end else begin
                        state <= DONE;
                        res   <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    res   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rails_dispatch.md
RAILS_DISPATCH -- requirements
Module: rails_dispatch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 data  input  4  header word (car count n) followed by n target departure-order words.
REQ-005 in_valid  input  1  data is valid this cycle.
REQ-006 in_ready  output  1  block accepts data this cycle; a word transfers when in_valid and in_ready are both high.
REQ-007 op_valid  output  1  a station operation is offered.
REQ-008 op_pop  output  1  0 means PUSH (incoming car onto station stack), 1 means POP (stack top departs).
REQ-009 op_car  output  4  car number moved by the offered operation.
REQ-010 op_ready  input  1  consumer accepts the operation; it transfers when op_valid and op_ready are both high.
REQ-011 done  output  1  one-cycle pulse marking the end of a problem.
REQ-012 result  output  1  valid only while done=1; 1 means the order is feasible and fully dispatched, 0 means infeasible or invalid.

Function
REQ-013 The FSM SHALL have four states, IDLE, LOAD, RUN and DONE; in_ready SHALL be 1 only in IDLE and LOAD.
REQ-014 IDLE: an accepted word is n. For n in 1..10, the block SHALL store n and go to LOAD. For n=0 or n>10, it SHALL go to DONE with result=0 and consume no further words.
REQ-015 LOAD: the block SHALL store the accepted words into target[0..n-1] in order; it SHALL NOT advance while in_valid=0.
REQ-016 LOAD: any target word equal to 0 or greater than n SHALL set a sticky bad flag.
REQ-017 When the n-th target word is accepted, the FSM SHALL go to DONE with result=0 if bad is set, otherwise to RUN; RUN init is nxt=1, k=0, stack empty (sp=0).
REQ-018 RUN, each cycle, priority order: (a) if sp>0 and stack top == target[k], the block SHALL offer POP with op_car=top; (b) else if nxt<=n, it SHALL offer PUSH with op_car=nxt; (c) else it SHALL set op_valid=0 and go to DONE with result=0.
REQ-019 op_valid, op_pop and op_car SHALL be derived from current registers only, with no combinational path from op_ready.
REQ-020 An offered operation SHALL remain stable until it transfers.
REQ-021 On a PUSH transfer, the block SHALL write nxt to stack[sp] and increment sp and nxt.
REQ-022 On a POP transfer, the block SHALL decrement sp and increment k.
REQ-023 A POP transfer with k==n-1 SHALL go to DONE with result=1.
REQ-024 The first operation SHALL be offered in the cycle after the last target word is accepted; with op_ready held at 1, one operation SHALL transfer per cycle.
REQ-025 A feasible problem SHALL emit exactly 2n operations.
REQ-026 The stack SHALL hold 10 entries of 4 bits; sp SHALL be 4 bits and never exceed n.
REQ-027 nxt SHALL be 5 bits wide so that nxt=n+1 does not wrap.
REQ-028 DONE SHALL last exactly one cycle with done=1, then go to IDLE; a new header SHALL be accepted in the following cycle.
REQ-029 Duplicate target values SHALL need no explicit check and SHALL resolve to result=0 through rule (c).
REQ-030 In RUN and DONE, in_valid SHALL be ignored and no word consumed.

Reset
REQ-031 On reset=1 at a clock edge, the block SHALL enter IDLE, clear n, k, sp, nxt, bad and the target/stack arrays, and abort any problem in progress.
REQ-032 After reset: in_ready=1, op_valid=0, op_pop=0, op_car=0, done=0, result=0.
REQ-033 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-034 n=3, order 1,2,3, op_ready=1 -> PUSH1, POP1, PUSH2, POP2, PUSH3, POP3 on consecutive cycles, first op the cycle after the last word, then done=1 and result=1.
REQ-035 n=3, order 3,1,2 -> PUSH1, PUSH2, PUSH3, POP3, then one cycle with op_valid=0, then done=1 and result=0 (4 ops total).
REQ-036 n=5, order 5,4,3,2,1 -> PUSH1..PUSH5 then POP5..POP1, done=1 and result=1, 10 ops.
REQ-037 Case of REQ-034 with op_ready=0 for 3 cycles at the POP2 offer -> op_pop=1 and op_car=2 held stable for the stall; sequence and result unchanged.
REQ-038 Invalid inputs: header 4 then 2,7,1,3 -> no op_valid, done=1 and result=0 the cycle after word 3 is accepted; header 0 or header 12 -> done=1 and result=0 the cycle after the header, with in_ready=0 during DONE.
REQ-039 Reset mid-RUN (after PUSH2 in the REQ-035 case) -> next cycle op_valid=0, done=0, in_ready=1; a following REQ-034 problem completes with result=1.
